mempool_dma_split: RTL
======================

Name: mempool_dma_split

Overview:
Parametrised DMA frontend splitter for a MemPool group. It accepts one linear DMA transfer (src, dst, num_bytes, id) and cuts it into dst-aligned chunks. Each chunk is dispatched to one of NumBackends DMA backends, selected by dst address interleaving. The block tracks outstanding chunks, aggregates backend completions, and pulses a single completion for the whole transfer. It sits between the group DMA control registers and the per-tile-cluster DMA backends.

Parameters:
AddrWidth, 32, width of src/dst addresses
NumBackends, 4, number of backends; power of two, >=1
ChunkBytes, 64, maximum chunk size and dst alignment; power of two, >=16
MaxOutstanding, 8, maximum chunks issued but not yet done; >=1
IdWidth, 2, transfer id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  transfer request valid
req_ready_o  out  1  request accepted when valid&ready
req_src_i  in  AddrWidth  source byte address
req_dst_i  in  AddrWidth  destination byte address
req_num_bytes_i  in  32  transfer length in bytes
req_id_i  in  IdWidth  transfer id
be_valid_o  out  NumBackends  one-hot chunk valid per backend
be_ready_i  in  NumBackends  backend accepts chunk
be_src_o  out  AddrWidth  chunk source address (shared by all backends)
be_dst_o  out  AddrWidth  chunk destination address
be_num_bytes_o  out  $clog2(ChunkBytes)+1  chunk length, 1..ChunkBytes
be_id_o  out  IdWidth  id of the owning transfer
be_done_i  in  NumBackends  one-cycle pulse per completed chunk
busy_o  out  1  high whenever the FSM is not in IDLE
complete_o  out  1  one-cycle transfer completion pulse
complete_id_o  out  IdWidth  id of the completed transfer, valid with complete_o
err_o  out  1  sticky: done received with zero outstanding

Behaviour:
- Reset (asynchronous): FSM=IDLE; outstanding=0; all outputs 0; err_o=0; registered src/dst/remaining/id cleared.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready_o=1.
  - On accept: latch src, dst, remaining=num_bytes, id.
  - Go to ISSUE if num_bytes!=0, else go to DRAIN.
- ISSUE, chunk computation (combinational from registered state):
  - len = min(remaining, ChunkBytes - (dst & (ChunkBytes-1))).
  - Backend index = (dst >> log2(ChunkBytes)) mod NumBackends.
- ISSUE, presenting a chunk:
  - be_valid_o asserts only that backend's bit, and only when outstanding < MaxOutstanding.
  - Once asserted, valid and payload hold stable until ready; valid is never withdrawn.
- ISSUE, on handshake:
  - src += len, dst += len, remaining -= len, outstanding += 1.
  - If remaining becomes 0, go to DRAIN.
  - At most one chunk is issued per cycle, so the first chunk appears the cycle after request accept.
- Completions:
  - Each cycle, outstanding += issued - popcount(be_done_i). Simultaneous issue and done(s) net correctly.
  - A done arriving while outstanding=0, with no same-cycle issue, is ignored and sets err_o.
- DRAIN:
  - When outstanding==0 (after applying this cycle's dones), assert complete_o with complete_id_o for one cycle, registered.
  - In that same transition, return to IDLE.
  - Zero-length request: complete_o pulses 2 cycles after accept.
- req_ready_o=0 in ISSUE and DRAIN. It returns to 1 in the cycle complete_o pulses, so back-to-back transfers are possible.
- Address arithmetic wraps modulo 2^AddrWidth; no error is raised.
- Reset mid-operation aborts immediately: outstanding is discarded, and no complete_o is emitted for the aborted transfer.
- Outstanding counter width is $clog2(MaxOutstanding+1); it must never overflow.

Test Plan:
1. Aligned: dst=0x1000, src=0x8000, 256 B, all ready=1 -> 4 chunks of 64 B to backends 0,1,2,3 on cycles 1..4 with src 0x8000/0x8040/0x8080/0x80C0. Dones on cycle 6 -> complete_o on cycle 7 with the request id.
2. Unaligned: dst=0x1030, src=0x2004, 100 B -> three chunks:
   - 16 B to be0, dst=0x1030, src=0x2004
   - 64 B to be1, dst=0x1040, src=0x2014
   - 20 B to be2, dst=0x1080, src=0x2054
   Sum of chunk lengths equals 100.
3. Zero length: num_bytes=0, id=3 -> no be_valid_o; complete_o=1 with id 3 exactly 2 cycles after accept; busy_o high for those cycles only.
4. Outstanding limit: 1024 B aligned, no dones -> exactly 8 chunks issued, then valid stays low. One done pulse -> the 9th chunk's valid asserts the following cycle. Dones from 2 backends in the same cycle reduce outstanding by 2.
5. Backpressure: be_ready_i held low for 5 cycles on the target backend -> be_valid_o and payload stable throughout; issue resumes on ready; req_ready_o stays 0.
6. Reset and error: rst_ni asserted mid-ISSUE -> all outputs 0 asynchronously, no complete_o after release, new request accepted normally. A spurious be_done_i in IDLE sets err_o, which stays set until reset.

Source files
------------

// File: rtl/mempool_dma_split_if.sv
// Bus bundle for mempool_dma_split: the transfer request from the group DMA
// control registers, the per-backend chunk channel, and the completion/status
// outputs.
//   master : the splitter's view (consumes requests, drives chunks/status)
//   slave  : the environment's view (issues requests, accepts chunks)
interface mempool_dma_split_if #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned NumBackends = 4,
  parameter int unsigned ChunkBytes  = 64,
  parameter int unsigned IdWidth     = 2
);
  localparam int unsigned LenW = $clog2(ChunkBytes) + 1;

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [AddrWidth-1:0]   req_src_i;
  logic [AddrWidth-1:0]   req_dst_i;
  logic [31:0]            req_num_bytes_i;
  logic [IdWidth-1:0]     req_id_i;

  logic [NumBackends-1:0] be_valid_o;
  logic [NumBackends-1:0] be_ready_i;
  logic [AddrWidth-1:0]   be_src_o;
  logic [AddrWidth-1:0]   be_dst_o;
  logic [LenW-1:0]        be_num_bytes_o;
  logic [IdWidth-1:0]     be_id_o;
  logic [NumBackends-1:0] be_done_i;

  logic                   busy_o;
  logic                   complete_o;
  logic [IdWidth-1:0]     complete_id_o;
  logic                   err_o;

  modport master (
    input  req_valid_i, req_src_i, req_dst_i, req_num_bytes_i, req_id_i,
           be_ready_i, be_done_i,
    output req_ready_o, be_valid_o, be_src_o, be_dst_o, be_num_bytes_o,
           be_id_o, busy_o, complete_o, complete_id_o, err_o
  );

  modport slave (
    output req_valid_i, req_src_i, req_dst_i, req_num_bytes_i, req_id_i,
           be_ready_i, be_done_i,
    input  req_ready_o, be_valid_o, be_src_o, be_dst_o, be_num_bytes_o,
           be_id_o, busy_o, complete_o, complete_id_o, err_o
  );
endinterface

// File: rtl/mempool_dma_split.sv
// DMA frontend splitter for a MemPool group. Cuts one linear transfer into
// dst-aligned chunks of at most ChunkBytes, steers each chunk to the backend
// selected by dst interleaving, limits in-flight chunks to MaxOutstanding,
// and pulses complete_o once every chunk of the transfer has reported done.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : request, per-backend chunk channel and status (master modport)
module mempool_dma_split #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned NumBackends    = 4,
  parameter int unsigned ChunkBytes     = 64,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned IdWidth        = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mempool_dma_split_if.master  bus
);
  localparam int unsigned OffW = $clog2(ChunkBytes);
  localparam int unsigned LenW = OffW + 1;
  localparam int unsigned IdxW = (NumBackends > 1) ? $clog2(NumBackends) : 1;
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   src_q, src_d, dst_q, dst_d;
  logic [31:0]            rem_q, rem_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [OutW-1:0]        out_q, out_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   complete_q, complete_d;
  logic [IdWidth-1:0]     complete_id_q, complete_id_d;

  logic [LenW-1:0]        space, len;
  logic [IdxW-1:0]        be_idx;
  logic                   can_issue, issue, accept;
  logic [NumBackends-1:0] valid;
  int unsigned            done_cnt, total;

  // Chunk geometry comes purely from registered state, so the payload cannot
  // change while a chunk waits for ready.
  always_comb begin
    space = LenW'(ChunkBytes) - {1'b0, dst_q[OffW-1:0]};
    if (rem_q < 32'(space)) len = rem_q[LenW-1:0];
    else                    len = space;
    be_idx = '0;
    if (NumBackends > 1) be_idx = dst_q[OffW +: IdxW];
    // out_q never rises without a handshake, so valid is never withdrawn.
    can_issue = (state_q == ISSUE) && (out_q < OutW'(MaxOutstanding));
    valid     = can_issue ? (NumBackends'(1) << be_idx) : '0;
    issue     = |(valid & bus.be_ready_i);
  end

  // Outstanding bookkeeping: dones in excess of what is in flight (including
  // a same-cycle issue) are dropped and flag the sticky error.
  always_comb begin
    done_cnt = 0;
    for (int unsigned i = 0; i < NumBackends; i++)
      done_cnt += {31'b0, bus.be_done_i[i]};
    total = 32'(out_q) + {31'b0, issue};
    err_d = err_q;
    if (done_cnt > total) begin
      err_d = 1'b1;
      out_d = '0;
    end else begin
      out_d = OutW'(total - done_cnt);
    end
  end

  assign accept = ready_q & bus.req_valid_i;

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    rem_d         = rem_q;
    id_d          = id_q;
    complete_d    = 1'b0;
    complete_id_d = complete_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d   = bus.req_src_i;
          dst_d   = bus.req_dst_i;
          rem_d   = bus.req_num_bytes_i;
          id_d    = bus.req_id_i;
          state_d = (bus.req_num_bytes_i != '0) ? ISSUE : DRAIN;
        end
      end
      ISSUE: begin
        if (issue) begin
          src_d = src_q + AddrWidth'(len);
          dst_d = dst_q + AddrWidth'(len);
          rem_d = rem_q - 32'(len);
          if (rem_d == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_d == '0) begin
          complete_d    = 1'b1;
          complete_id_d = id_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready keeps every output low during reset yet rises in the
    // same cycle complete_o pulses.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      id_q          <= '0;
      out_q         <= '0;
      err_q         <= 1'b0;
      ready_q       <= 1'b0;
      complete_q    <= 1'b0;
      complete_id_q <= '0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      rem_q         <= rem_d;
      id_q          <= id_d;
      out_q         <= out_d;
      err_q         <= err_d;
      ready_q       <= ready_d;
      complete_q    <= complete_d;
      complete_id_q <= complete_id_d;
    end
  end

  assign bus.req_ready_o    = ready_q;
  assign bus.be_valid_o     = valid;
  assign bus.be_src_o       = src_q;
  assign bus.be_dst_o       = dst_q;
  assign bus.be_num_bytes_o = len;
  assign bus.be_id_o        = id_q;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.complete_o     = complete_q;
  assign bus.complete_id_o  = complete_id_q;
  assign bus.err_o          = err_q;
endmodule
